// File: rtl/usb_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer_if
// Description : Signal bundle between the USB TX sequencer and its
//               environment (packet buffer, CRC16 unit, bit stuffer).
//               master = environment side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_sequencer_if;
  // bit timing from the clock divider / bit stuffer
  logic       bit_tick;
  logic       stuff_stall;
  // packet request
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  // data byte source
  logic [7:0] data_byte;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  // CRC16 unit control and return path
  logic       crc_bit_in;
  logic       crc_new_bit;
  logic       crc_reset;
  logic       crc_calc;
  logic       crc_send;
  logic       crc_serial;
  // serial stream to the bit stuffer and status
  logic       tx_bit;
  logic       tx_bit_valid;
  logic       tx_eop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output bit_tick, stuff_stall, tx_start, tx_pid, tx_has_data,
           data_byte, data_valid, data_last, crc_send, crc_serial,
    input  data_ready, crc_bit_in, crc_new_bit, crc_reset, crc_calc,
           tx_bit, tx_bit_valid, tx_eop, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  bit_tick, stuff_stall, tx_start, tx_pid, tx_has_data,
           data_byte, data_valid, data_last, crc_send, crc_serial,
    output data_ready, crc_bit_in, crc_new_bit, crc_reset, crc_calc,
           tx_bit, tx_bit_valid, tx_eop, tx_busy, tx_done, tx_error
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer
// Description : USB transmit packet sequencer. Serialises SYNC, PID, data
//               bytes, CRC16 and EOP into one LSB-first bit stream for the
//               bit stuffer, and drives the CRC16 unit's control inputs.
//               Optional macro USB_TX_SEQ_SYNC_EN: when defined, the SYNC
//               byte (0x80) is generated here ahead of the PID; otherwise
//               SYNC is left to the downstream logic.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer #(
  parameter int CRC_WAIT_MAX = 32   // 1..63 cycles from crc_calc to crc_send
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC     = 3'd1,
    S_PID      = 3'd2,
    S_DATA     = 3'd3,
    S_CRC_WAIT = 3'd4,
    S_CRC_OUT  = 3'd5,
    S_EOP      = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam logic [5:0] c_wait_last = 6'(CRC_WAIT_MAX - 1);
`ifdef USB_TX_SEQ_SYNC_EN
  localparam logic [7:0] c_sync = 8'h80;
`endif

  state_t     r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_pid;
  logic       r_has_data;
  logic       r_have_byte;   // a data byte is loaded and still being shifted
  logic       r_last;        // loaded byte is the final one
  logic       r_gap;         // one etick already passed without a byte
  logic       r_error;
  logic       r_crc_reset;
  logic [5:0] r_wait_cnt;
  logic [3:0] r_crc_cnt;
  logic [1:0] r_eop_cnt;

  logic w_start, w_etick, w_shift_state, w_emit, w_byte_end;
  logic w_load, w_miss, w_timeout, w_tx_bit;

  assign w_start       = (r_state == S_IDLE) && bus.tx_start;
  // The stuffer cannot stall the line while SE0/J is being driven.
  assign w_etick       = (r_state == S_EOP) ? bus.bit_tick
                                            : (bus.bit_tick & ~bus.stuff_stall);
  assign w_shift_state = (r_state == S_SYNC) || (r_state == S_PID) ||
                         ((r_state == S_DATA) && r_have_byte);
  // No bit in the CRC reset cycle so the CRC unit never sees a bit early.
  assign w_emit        = w_etick & ~r_crc_reset &
                         (w_shift_state | (r_state == S_CRC_OUT));
  assign w_byte_end    = w_emit & w_shift_state & (r_bit_cnt == 3'd7);
  assign w_load        = (r_state == S_DATA) & ~r_have_byte & bus.data_valid;
  assign w_miss        = (r_state == S_DATA) & ~r_have_byte & ~bus.data_valid & w_etick;
  assign w_timeout     = (r_state == S_CRC_WAIT) & ~bus.crc_send &
                         (r_wait_cnt >= c_wait_last);
  assign w_tx_bit      = w_shift_state            ? r_shift[0]     :
                         (r_state == S_CRC_OUT)   ? bus.crc_serial : 1'b0;

  assign bus.tx_bit       = w_tx_bit;
  assign bus.tx_bit_valid = w_emit;
  assign bus.data_ready   = w_load;
  assign bus.crc_new_bit  = w_emit & (r_state == S_DATA);
  assign bus.crc_bit_in   = (r_state == S_DATA) ? w_tx_bit : 1'b0;
  assign bus.crc_reset    = r_crc_reset;
  assign bus.crc_calc     = (r_state == S_CRC_WAIT) || (r_state == S_CRC_OUT);
  assign bus.tx_eop       = (r_state == S_EOP) && (r_eop_cnt != 2'd2);
  assign bus.tx_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.tx_done      = (r_state == S_DONE);
  assign bus.tx_error     = r_error;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.tx_start) begin
`ifdef USB_TX_SEQ_SYNC_EN
          w_next = S_SYNC;
`else
          w_next = S_PID;
`endif
        end
      end
      S_SYNC:     if (w_byte_end) w_next = S_PID;
      S_PID:      if (w_byte_end) w_next = r_has_data ? S_DATA : S_EOP;
      S_DATA: begin
        if (w_miss && r_gap)              w_next = S_EOP;
        else if (w_byte_end && r_last)    w_next = S_CRC_WAIT;
      end
      S_CRC_WAIT: begin
        if (bus.crc_send)                 w_next = S_CRC_OUT;
        else if (w_timeout)               w_next = S_EOP;
      end
      S_CRC_OUT:  if (w_emit && (r_crc_cnt == 4'd15)) w_next = S_EOP;
      S_EOP:      if (w_etick && (r_eop_cnt == 2'd2)) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Packet capture, shift register, byte loading and error flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_pid       <= 4'h0;
      r_has_data  <= 1'b0;
      r_have_byte <= 1'b0;
      r_last      <= 1'b0;
      r_gap       <= 1'b0;
      r_error     <= 1'b0;
      r_crc_reset <= 1'b0;
    end else begin
      r_crc_reset <= w_start;
      if (w_start) begin
        r_pid       <= bus.tx_pid;
        r_has_data  <= bus.tx_has_data;
        r_error     <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_have_byte <= 1'b0;
        r_gap       <= 1'b0;
`ifdef USB_TX_SEQ_SYNC_EN
        r_shift     <= c_sync;
`else
        r_shift     <= {~bus.tx_pid, bus.tx_pid};
`endif
      end else if (w_load) begin
        r_shift     <= bus.data_byte;
        r_last      <= bus.data_last;
        r_have_byte <= 1'b1;
        r_gap       <= 1'b0;
        r_bit_cnt   <= 3'd0;
      end else if (w_emit && w_shift_state) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          r_have_byte <= 1'b0;
          r_shift     <= (r_state == S_SYNC) ? {~r_pid, r_pid} : (r_shift >> 1);
        end else begin
          r_shift     <= r_shift >> 1;
        end
      end
      // First missed etick is a tolerated gap, the second aborts the packet.
      if (w_miss) begin
        r_gap <= 1'b1;
        if (r_gap) r_error <= 1'b1;
      end
      if (w_timeout) r_error <= 1'b1;
    end
  end

  // Per-state counters; each clears whenever its state is not active.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wait_cnt <= 6'd0;
      r_crc_cnt  <= 4'd0;
      r_eop_cnt  <= 2'd0;
    end else begin
      if (r_state != S_CRC_WAIT)     r_wait_cnt <= 6'd0;
      else if (r_wait_cnt != 6'h3F)  r_wait_cnt <= r_wait_cnt + 6'd1;

      if (r_state != S_CRC_OUT)      r_crc_cnt <= 4'd0;
      else if (w_emit)               r_crc_cnt <= r_crc_cnt + 4'd1;

      if (r_state != S_EOP)          r_eop_cnt <= 2'd0;
      else if (w_etick)              r_eop_cnt <= r_eop_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire
